disparity_select: RTL

DISPARITY_SELECT -- requirements
Module: disparity_select

---
 rtl/stereo_pkg.sv | 14 +
 rtl/disparity_select_if.sv | 35 +++
 rtl/ssd_min2_tracker.sv | 55 +++++
 rtl/disparity_select.sv | 118 +++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo disparity pipeline: SSD and coordinate
// widths plus the block-search state encoding.
package stereo_pkg;

  localparam int SSD_W   = 23;
  localparam int COORD_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/disparity_select_if.sv
// Candidate-stream and result bundle for disparity_select; the slave modport
// is the selector's view, master is the producer/consumer side.
interface disparity_select_if #(
  parameter int SSD_W  = stereo_pkg::SSD_W,
  parameter int DISP_W = 4
);
  import stereo_pkg::COORD_W;

  logic               start_in;
  logic [COORD_W-1:0] block_x_in;
  logic [COORD_W-1:0] block_y_in;
  logic               valid_in;
  logic [SSD_W-1:0]   ssd_in;

  logic               busy_out;
  logic               valid_out;
  logic [DISP_W-1:0]  disp_out;
  logic [SSD_W-1:0]   min_ssd_out;
  logic               confident_out;
  logic [COORD_W-1:0] block_x_out;
  logic [COORD_W-1:0] block_y_out;

  modport master (
    output start_in, block_x_in, block_y_in, valid_in, ssd_in,
    input  busy_out, valid_out, disp_out, min_ssd_out, confident_out,
           block_x_out, block_y_out
  );

  modport slave (
    input  start_in, block_x_in, block_y_in, valid_in, ssd_in,
    output busy_out, valid_out, disp_out, min_ssd_out, confident_out,
           block_x_out, block_y_out
  );

endinterface

// File: rtl/ssd_min2_tracker.sv
// Tracks the smallest and second-smallest SSD seen in a block search and the
// index of the smallest; exposes next-state values so the caller can register
// the final result on the same edge as the last candidate.
module ssd_min2_tracker #(
  parameter int SSD_W = 23,
  parameter int IDX_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_init,
  input  logic             i_accept,
  input  logic [SSD_W-1:0] i_ssd,
  input  logic [IDX_W-1:0] i_idx,
  output logic [SSD_W-1:0] o_best_nxt,
  output logic [SSD_W-1:0] o_second_nxt,
  output logic [IDX_W-1:0] o_idx_nxt
);

  logic [SSD_W-1:0] r_best;
  logic [SSD_W-1:0] r_second;
  logic [IDX_W-1:0] r_idx;

  // Strict less-than keeps the lowest index on ties; an equal value only lands in second.
  always_comb begin
    o_best_nxt   = r_best;
    o_second_nxt = r_second;
    o_idx_nxt    = r_idx;
    if (i_init) begin
      o_best_nxt   = '1;
      o_second_nxt = '1;
      o_idx_nxt    = '0;
    end else if (i_accept) begin
      if (i_ssd < r_best) begin
        o_second_nxt = r_best;
        o_best_nxt   = i_ssd;
        o_idx_nxt    = i_idx;
      end else if (i_ssd < r_second) begin
        o_second_nxt = i_ssd;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_best   <= '1;
      r_second <= '1;
      r_idx    <= '0;
    end else begin
      r_best   <= o_best_nxt;
      r_second <= o_second_nxt;
      r_idx    <= o_idx_nxt;
    end
  end

endmodule

// File: rtl/disparity_select.sv
// Winner-take-all disparity selection: scans MAX_DISP candidate SSDs per block
// and reports the best index, its SSD and a uniqueness-based confidence flag.
module disparity_select #(
  parameter int MAX_DISP    = 16,
  parameter int SSD_W       = stereo_pkg::SSD_W,
  parameter int UNIQ_THRESH = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in,
  disparity_select_if.slave bus
);
  import stereo_pkg::*;

  localparam int DISP_W = $clog2(MAX_DISP);
  localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(MAX_DISP - 1);
  localparam logic [SSD_W:0]    THRESH   = (SSD_W + 1)'(UNIQ_THRESH);

  state_t              r_state;
  logic [DISP_W-1:0]   r_count;
  logic [COORD_W-1:0]  r_bx;
  logic [COORD_W-1:0]  r_by;
  logic                r_busy;
  logic                r_valid;
  logic [DISP_W-1:0]   r_disp;
  logic [SSD_W-1:0]    r_min;
  logic                r_conf;
  logic [COORD_W-1:0]  r_xout;
  logic [COORD_W-1:0]  r_yout;

  logic                w_accept;
  logic                w_last;
  logic [SSD_W-1:0]    w_best_nxt;
  logic [SSD_W-1:0]    w_second_nxt;
  logic [DISP_W-1:0]   w_idx_nxt;
  logic [SSD_W:0]      w_margin;

  // A start in ACCUM wins over a coincident sample, which is dropped.
  assign w_accept = (r_state == ACCUM) && bus.valid_in && !bus.start_in;
  assign w_last   = w_accept && (r_count == LAST_IDX);
  assign w_margin = {1'b0, w_second_nxt} - {1'b0, w_best_nxt};

  ssd_min2_tracker #(
    .SSD_W (SSD_W),
    .IDX_W (DISP_W)
  ) u_tracker (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_init       (bus.start_in),
    .i_accept     (w_accept),
    .i_ssd        (bus.ssd_in),
    .i_idx        (r_count),
    .o_best_nxt   (w_best_nxt),
    .o_second_nxt (w_second_nxt),
    .o_idx_nxt    (w_idx_nxt)
  );

  // Results are captured from the tracker's next values on the final accept,
  // so they are already fresh during the EMIT cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_count <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_disp  <= '0;
      r_min   <= '0;
      r_conf  <= 1'b0;
      r_xout  <= '0;
      r_yout  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (bus.start_in) begin
        r_state <= ACCUM;
        r_count <= '0;
        r_bx    <= bus.block_x_in;
        r_by    <= bus.block_y_in;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ACCUM: begin
            if (w_accept) begin
              r_count <= r_count + DISP_W'(1);
            end
            if (w_last) begin
              r_state <= EMIT;
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
              r_disp  <= w_idx_nxt;
              r_min   <= w_best_nxt;
              r_conf  <= (w_margin >= THRESH);
              r_xout  <= r_bx;
              r_yout  <= r_by;
            end
          end
          EMIT: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy_out      = r_busy;
  assign bus.valid_out     = r_valid;
  assign bus.disp_out      = r_disp;
  assign bus.min_ssd_out   = r_min;
  assign bus.confident_out = r_conf;
  assign bus.block_x_out   = r_xout;
  assign bus.block_y_out   = r_yout;

endmodule
